// File: rtl/digit_sequencer.sv
// digit_sequencer: steps a digit-select code through NUM_DIGITS positions on a
// trigger. Each digit is shown for DISPLAY_TIME cycles and followed by a blank
// gap of PAUSE_TIME cycles. The sequencer supports one-shot or looping passes,
// a synchronous abort, busy/blank status and a one-cycle completion pulse.
// The `state` output drives the 7-segment digit mux; IDLE_CODE (all ones)
// means the display is off.
//
// Optional feature: define DIGIT_SEQ_HOLD_EN to add a `hold` input. While
// hold is high in SHOW or GAP, the sequencer freezes and every output keeps
// its value. abort and rst_n still take effect during hold.
module digit_sequencer #(
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned DISPLAY_TIME = 1000,
  parameter int unsigned PAUSE_TIME   = 500,
  parameter int unsigned CNT_W        = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             loop_mode,
  input  logic             abort,
`ifdef DIGIT_SEQ_HOLD_EN
  input  logic             hold,
`endif
  output logic [IDX_W-1:0] state,
  output logic             busy,
  output logic             blank,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } fsm_e;

  localparam logic [IDX_W-1:0] IDLE_CODE  = '1;
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DISPLAY_TIME - 1);
  localparam bit               HAS_GAP    = (PAUSE_TIME > 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = HAS_GAP ? CNT_W'(PAUSE_TIME - 1) : '0;

  fsm_e             fsm_q,   fsm_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] digit_q, digit_d;
  logic [IDX_W-1:0] state_q, state_d;
  logic             busy_q,  busy_d;
  logic             blank_q, blank_d;
  logic             done_q,  done_d;
  logic             digit_end;
  logic             hold_w;

`ifdef DIGIT_SEQ_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // Next-state logic. Priority: abort, then hold while active, then normal sequencing.
  always_comb begin
    fsm_d     = fsm_q;
    timer_d   = timer_q;
    digit_d   = digit_q;
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    digit_end = 1'b0;

    if (abort) begin
      fsm_d   = ST_IDLE;
      timer_d = '0;
      digit_d = '0;
      state_d = IDLE_CODE;
      busy_d  = 1'b0;
    end else if (hold_w && (fsm_q != ST_IDLE)) begin
      // Frozen: every register keeps its value, including a pending done pulse.
      done_d = done_q;
    end else begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (trigger) begin
            fsm_d   = ST_SHOW;
            timer_d = '0;
            digit_d = '0;
            state_d = '0;
            busy_d  = 1'b1;
          end
        end
        ST_SHOW: begin
          if (timer_q == SHOW_LAST) begin
            timer_d = '0;
            if (HAS_GAP) begin
              fsm_d   = ST_GAP;
              state_d = IDLE_CODE;
            end else begin
              digit_end = 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_d   = '0;
            digit_end = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          fsm_d   = ST_IDLE;
          timer_d = '0;
          digit_d = '0;
          state_d = IDLE_CODE;
          busy_d  = 1'b0;
        end
      endcase

      // The end of a digit is shared by SHOW (no gap configured) and GAP.
      if (digit_end) begin
        if (digit_q != LAST_DIGIT) begin
          fsm_d   = ST_SHOW;
          digit_d = digit_q + 1'b1;
          state_d = digit_q + 1'b1;
        end else begin
          done_d  = 1'b1;
          digit_d = '0;
          if (loop_mode) begin
            fsm_d   = ST_SHOW;
            state_d = '0;
          end else begin
            fsm_d   = ST_IDLE;
            state_d = IDLE_CODE;
            busy_d  = 1'b0;
          end
        end
      end
    end

    // Digit indices never reach IDLE_CODE, so blank follows the code directly.
    blank_d = (state_d == IDLE_CODE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      timer_q <= '0;
      digit_q <= '0;
      state_q <= IDLE_CODE;
      busy_q  <= 1'b0;
      blank_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      timer_q <= timer_d;
      digit_q <= digit_d;
      state_q <= state_d;
      busy_q  <= busy_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end

  assign state = state_q;
  assign busy  = busy_q;
  assign blank = blank_q;
  assign done  = done_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// Testbench for digit_sequencer. There are two instances. Instance a has a
// blank gap (PAUSE_TIME=2) and instance b has none (PAUSE_TIME=0). Each output
// is compared with a pass-position model: a counter k of cycles into the pass,
// from which the expected digit/blank is obtained by division.
module tb_digit_sequencer;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int PA = 2;
  localparam int PB = 0;
  localparam int PASS_A = N * (D + PA);
  localparam int PASS_B = N * (D + PB);
  localparam logic [4:0] IDLE_VEC = 5'b11010;   // state=3, busy=0, blank=1, done=0

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trigger = 1'b0;
  logic loop_mode = 1'b0;
  logic abort = 1'b0;
  logic hold = 1'b0;

  logic [1:0] state_a, state_b;
  logic busy_a, blank_a, done_a, busy_b, blank_b, done_b;
  logic [4:0] obs_a, obs_b, exp_a, exp_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_sequencer #(.NUM_DIGITS(N), .IDX_W(2), .DISPLAY_TIME(D), .PAUSE_TIME(PA), .CNT_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .loop_mode(loop_mode), .abort(abort),
`ifdef DIGIT_SEQ_HOLD_EN
    .hold(hold),
`endif
    .state(state_a), .busy(busy_a), .blank(blank_a), .done(done_a));

  digit_sequencer #(.NUM_DIGITS(N), .IDX_W(2), .DISPLAY_TIME(D), .PAUSE_TIME(PB), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .loop_mode(loop_mode), .abort(abort),
`ifdef DIGIT_SEQ_HOLD_EN
    .hold(hold),
`endif
    .state(state_b), .busy(busy_b), .blank(blank_b), .done(done_b));

  assign obs_a = {state_a, busy_a, blank_a, done_a};
  assign obs_b = {state_b, busy_b, blank_b, done_b};

  // Reference model: act / k (cycles since the trigger edge) / done per instance.
  logic ma_act, ma_done, mb_act, mb_done;
  int   ma_k, mb_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || abort) begin
      ma_act <= 1'b0; ma_k <= 0; ma_done <= 1'b0;
    end else if (ma_act && hold) begin
      ma_act <= ma_act;
    end else if (ma_act) begin
      if (ma_k + 1 == PASS_A) begin
        ma_done <= 1'b1; ma_k <= 0; ma_act <= loop_mode;
      end else begin
        ma_done <= 1'b0; ma_k <= ma_k + 1;
      end
    end else begin
      ma_done <= 1'b0;
      if (trigger) begin ma_act <= 1'b1; ma_k <= 0; end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || abort) begin
      mb_act <= 1'b0; mb_k <= 0; mb_done <= 1'b0;
    end else if (mb_act && hold) begin
      mb_act <= mb_act;
    end else if (mb_act) begin
      if (mb_k + 1 == PASS_B) begin
        mb_done <= 1'b1; mb_k <= 0; mb_act <= loop_mode;
      end else begin
        mb_done <= 1'b0; mb_k <= mb_k + 1;
      end
    end else begin
      mb_done <= 1'b0;
      if (trigger) begin mb_act <= 1'b1; mb_k <= 0; end
    end
  end

  function automatic logic [4:0] exp_vec(input logic act, input int k, input logic dn, input int p);
    int per;
    logic [1:0] st;
    per = D + p;
    if (!act) return {2'd3, 1'b0, 1'b1, dn};
    if ((k % per) < D) st = 2'(k / per);
    else st = 2'd3;
    return {st, 1'b1, (st == 2'd3), dn};
  endfunction

  always_comb begin
    exp_a = exp_vec(ma_act, ma_k, ma_done, PA);
    exp_b = exp_vec(mb_act, mb_k, mb_done, PB);
  end

  task automatic test_reset();
    rst_n = 1'b0; trigger = 1'b0; loop_mode = 1'b0; abort = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (obs_a !== IDLE_VEC) begin n_fail++; $display("FAIL reset_a: got %b exp %b", obs_a, IDLE_VEC); end
    if (obs_b !== IDLE_VEC) begin n_fail++; $display("FAIL reset_b: got %b exp %b", obs_b, IDLE_VEC); end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_checks += 2;
      if (obs_a !== IDLE_VEC) begin n_fail++; $display("FAIL reset_idle_a: got %b exp %b", obs_a, IDLE_VEC); end
      if (obs_b !== IDLE_VEC) begin n_fail++; $display("FAIL reset_idle_b: got %b exp %b", obs_b, IDLE_VEC); end
    end
  endtask

  task automatic test_one_shot();
    int t0, lat_a, lat_b;
    trigger = 1'b1; loop_mode = 1'b0;
    @(negedge clk);
    trigger = 1'b0; t0 = cyc; lat_a = 0; lat_b = 0;
    n_checks += 2;
    if (obs_a !== exp_a) begin n_fail++; $display("FAIL one_shot_start_a: got %b exp %b", obs_a, exp_a); end
    if (obs_b !== exp_b) begin n_fail++; $display("FAIL one_shot_start_b: got %b exp %b", obs_b, exp_b); end
    for (int i = 0; i < 30 && lat_a == 0; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL one_shot_a @%0d: got %b exp %b", cyc - t0, obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL one_shot_b @%0d: got %b exp %b", cyc - t0, obs_b, exp_b); end
      if (done_a === 1'b1) lat_a = cyc - t0;
      if (done_b === 1'b1) lat_b = cyc - t0;
    end
    n_checks += 2;
    if (lat_a != PASS_A) begin n_fail++; $display("FAIL one_shot_latency_a: got %0d exp %0d", lat_a, PASS_A); end
    if (lat_b != PASS_B) begin n_fail++; $display("FAIL one_shot_latency_b: got %0d exp %0d", lat_b, PASS_B); end
    @(negedge clk);
  endtask

  task automatic test_loop();
    int dones, busy_low;
    bit idle;
    dones = 0; busy_low = 0; idle = 0;
    loop_mode = 1'b1; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (40) begin
      @(negedge clk);
      n_checks += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL loop_a: got %b exp %b", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL loop_b: got %b exp %b", obs_b, exp_b); end
      if (done_a === 1'b1) dones++;
      if (busy_a !== 1'b1) busy_low++;
    end
    n_checks += 2;
    if (dones != 2) begin n_fail++; $display("FAIL loop_done_count: got %0d exp 2", dones); end
    if (busy_low != 0) begin n_fail++; $display("FAIL loop_busy: got %0d low cycles exp 0", busy_low); end
    loop_mode = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL loop_exit_a: got %b exp %b", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL loop_exit_b: got %b exp %b", obs_b, exp_b); end
      if (busy_a === 1'b0 && busy_b === 1'b0) idle = 1;
    end
    n_checks++;
    if (!idle) begin n_fail++; $display("FAIL loop_exit_timeout: busy_a=%b busy_b=%b exp 0", busy_a, busy_b); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    // Abort while digit 1 is shown, with a trigger in the same cycle.
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1; trigger = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (obs_a !== IDLE_VEC) begin n_fail++; $display("FAIL abort_a: got %b exp %b", obs_a, IDLE_VEC); end
    if (obs_b !== exp_b) begin n_fail++; $display("FAIL abort_b: got %b exp %b", obs_b, exp_b); end
    abort = 1'b0; trigger = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (obs_a !== IDLE_VEC) begin n_fail++; $display("FAIL abort_stays_idle: got %b exp %b", obs_a, IDLE_VEC); end
    end
    // Abort coinciding with the end of a pass suppresses done.
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (17) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks += 2;
    if (obs_a !== IDLE_VEC) begin n_fail++; $display("FAIL abort_end_pass: got %b exp %b", obs_a, IDLE_VEC); end
    if (obs_b !== exp_b) begin n_fail++; $display("FAIL abort_end_pass_b: got %b exp %b", obs_b, exp_b); end
    @(negedge clk);
  endtask

  task automatic test_busy_trigger();
    int t0, lat;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0; t0 = cyc; lat = 0;
    for (int i = 1; i < 30 && lat == 0; i++) begin
      trigger = (i == 3 || i == 10) ? 1'b1 : 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL busy_trig_a: got %b exp %b", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL busy_trig_b: got %b exp %b", obs_b, exp_b); end
      if (done_a === 1'b1) lat = cyc - t0;
    end
    trigger = 1'b0;
    n_checks++;
    if (lat != PASS_A) begin n_fail++; $display("FAIL busy_trig_latency: got %0d exp %0d", lat, PASS_A); end
    @(negedge clk);
    // Asynchronous reset in the middle of a pass.
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (obs_a !== IDLE_VEC) begin n_fail++; $display("FAIL async_reset_a: got %b exp %b", obs_a, IDLE_VEC); end
    if (obs_b !== IDLE_VEC) begin n_fail++; $display("FAIL async_reset_b: got %b exp %b", obs_b, IDLE_VEC); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (obs_a !== IDLE_VEC) begin n_fail++; $display("FAIL post_reset_idle: got %b exp %b", obs_a, IDLE_VEC); end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    bit idle;
    d1 = 0; d2 = 0; idle = 0;
    loop_mode = 1'b0; trigger = 1'b1;
    for (int i = 0; i < 60 && d2 == 0; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL b2b_a: got %b exp %b", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL b2b_b: got %b exp %b", obs_b, exp_b); end
      if (done_a === 1'b1) begin
        if (d1 == 0) d1 = cyc; else d2 = cyc;
      end
    end
    n_checks++;
    if (d2 - d1 != PASS_A + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d exp %0d", d2 - d1, PASS_A + 1); end
    trigger = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (busy_a === 1'b0 && busy_b === 1'b0) idle = 1;
    end
    n_checks++;
    if (!idle) begin n_fail++; $display("FAIL b2b_idle_timeout: busy_a=%b busy_b=%b exp 0", busy_a, busy_b); end
    @(negedge clk);
  endtask

`ifdef DIGIT_SEQ_HOLD_EN
  task automatic test_hold();
    int t0, lat;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0; t0 = cyc; lat = 0;
    for (int i = 1; i < 40 && lat == 0; i++) begin
      hold = (i >= 1 && i <= 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL hold_a: got %b exp %b", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL hold_b: got %b exp %b", obs_b, exp_b); end
      if (done_b === 1'b1) lat = cyc - t0;
    end
    hold = 1'b0;
    n_checks++;
    if (lat != PASS_B + 3) begin n_fail++; $display("FAIL hold_latency_b: got %0d exp %0d", lat, PASS_B + 3); end
    repeat (12) @(negedge clk);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL random_a cyc %0d: got %b exp %b", cyc, obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL random_b cyc %0d: got %b exp %b", cyc, obs_b, exp_b); end
      trigger   = ($urandom_range(0, 3) == 0);
      loop_mode = ($urandom_range(0, 1) == 1);
      abort     = ($urandom_range(0, 63) == 0);
`ifdef DIGIT_SEQ_HOLD_EN
      hold      = ($urandom_range(0, 7) == 0);
`endif
    end
    trigger = 1'b0; loop_mode = 1'b0; abort = 1'b0; hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_loop();
    test_abort();
    test_busy_trigger();
    test_back_to_back();
`ifdef DIGIT_SEQ_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
